// File: rtl/mem_access_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory.
// One access is in flight at a time: IDLE grants, ACCESS issues the strobe,
// WAIT absorbs read wait states, RESP captures read data for the owner.
module mem_access_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  wait_cycles,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [9:0]  req0_addr,
  input  logic [15:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [9:0]  req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        rsp0_valid,
  output logic [15:0] rsp0_rdata,
  output logic        rsp1_valid,
  output logic [15:0] rsp1_rdata,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [9:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t     state_reg;
  logic       prio_reg;      // requester that wins when both are valid
  logic       owner_reg;     // requester of the access in flight
  logic       we_reg;        // latched direction of the access in flight
  logic [1:0] wait_reg;      // wait states captured at accept
  logic [1:0] cnt_reg;       // remaining wait states while in WAIT
  logic       grant0;
  logic       grant1;

  // Round-robin grant decision; only offered while idle so at most one fires.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_reg == IDLE) begin
      grant0 = req0_valid && (!req1_valid || !prio_reg);
      grant1 = req1_valid && (!req0_valid ||  prio_reg);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state_reg != IDLE);

  // Access sequencing FSM; memory address/data registers double as the
  // latched request fields, so they hold their value between accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      prio_reg   <= 1'b0;
      owner_reg  <= 1'b0;
      we_reg     <= 1'b0;
      wait_reg   <= 2'd0;
      cnt_reg    <= 2'd0;
      mem_wr_en  <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= 10'd0;
      mem_wdata  <= 16'd0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= 16'd0;
      rsp1_rdata <= 16'd0;
    end else begin
      // strobes and response pulses are single-cycle by default
      mem_wr_en  <= 1'b0;
      mem_rd_en  <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant0 || grant1) begin
            owner_reg <= grant1;
            wait_reg  <= wait_cycles;
            // the pointer moves to whoever was not granted
            prio_reg  <= grant0;
            if (grant1) begin
              we_reg    <= req1_we;
              mem_addr  <= req1_addr;
              mem_wdata <= req1_wdata;
              mem_wr_en <= req1_we;
              mem_rd_en <= !req1_we;
            end else begin
              we_reg    <= req0_we;
              mem_addr  <= req0_addr;
              mem_wdata <= req0_wdata;
              mem_wr_en <= req0_we;
              mem_rd_en <= !req0_we;
            end
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_reg) begin
            state_reg <= IDLE;
          end else if (wait_reg == 2'd0) begin
            state_reg <= RESP;
          end else begin
            cnt_reg   <= wait_reg;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 2'd1;
          if (cnt_reg == 2'd1) begin
            state_reg <= RESP;
          end
        end
        RESP: begin
          if (owner_reg) begin
            rsp1_rdata <= mem_rdata;
            rsp1_valid <= 1'b1;
          end else begin
            rsp0_rdata <= mem_rdata;
            rsp0_valid <= 1'b1;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
